// File: rtl/mask_unit_read_response_gather.sv
`default_nettype none
// ============================================================================
// Module   : mask_unit_read_response_gather
// Purpose  : Gathers four lanes of crossbar read responses into one 4-slot
//            group keyed by writeIndex, with a no-progress timeout.
// Revision : 1.0
// ============================================================================
module mask_unit_read_response_gather #(
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start_valid,
    output logic                    start_ready,
    input  logic [3:0]              start_bits_expect,
    input  logic                    resp_0_valid,
    output logic                    resp_0_ready,
    input  logic [DATA_WIDTH-1:0]   resp_0_bits_data,
    input  logic [1:0]              resp_0_bits_writeIndex,
    input  logic [1:0]              resp_0_bits_dataOffset,
    input  logic                    resp_1_valid,
    output logic                    resp_1_ready,
    input  logic [DATA_WIDTH-1:0]   resp_1_bits_data,
    input  logic [1:0]              resp_1_bits_writeIndex,
    input  logic [1:0]              resp_1_bits_dataOffset,
    input  logic                    resp_2_valid,
    output logic                    resp_2_ready,
    input  logic [DATA_WIDTH-1:0]   resp_2_bits_data,
    input  logic [1:0]              resp_2_bits_writeIndex,
    input  logic [1:0]              resp_2_bits_dataOffset,
    input  logic                    resp_3_valid,
    output logic                    resp_3_ready,
    input  logic [DATA_WIDTH-1:0]   resp_3_bits_data,
    input  logic [1:0]              resp_3_bits_writeIndex,
    input  logic [1:0]              resp_3_bits_dataOffset,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [4*DATA_WIDTH-1:0] out_bits_data,
    output logic [3:0]              out_bits_mask,
    output logic                    out_bits_error
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [3:0]            r_expect;
    logic [3:0]            r_mask;
    logic                  r_error;
    logic [7:0]            r_tcnt;
    logic [DATA_WIDTH-1:0] r_slot [4];

    logic [3:0]            w_valid;
    logic [1:0]            w_widx  [4];
    logic [1:0]            w_off   [4];
    logic [DATA_WIDTH-1:0] w_data  [4];
    logic [DATA_WIDTH-1:0] w_shift [4];
    logic [3:0]            w_ready;
    logic [3:0]            w_accept;
    logic [3:0]            w_good;
    logic [3:0]            w_fill;
    logic                  w_bad;
    logic                  w_tcnt_hit;
    logic                  w_timeout;

    assign w_valid  = {resp_3_valid, resp_2_valid, resp_1_valid, resp_0_valid};
    assign w_widx[0] = resp_0_bits_writeIndex;
    assign w_widx[1] = resp_1_bits_writeIndex;
    assign w_widx[2] = resp_2_bits_writeIndex;
    assign w_widx[3] = resp_3_bits_writeIndex;
    assign w_off[0]  = resp_0_bits_dataOffset;
    assign w_off[1]  = resp_1_bits_dataOffset;
    assign w_off[2]  = resp_2_bits_dataOffset;
    assign w_off[3]  = resp_3_bits_dataOffset;
    assign w_data[0] = resp_0_bits_data;
    assign w_data[1] = resp_1_bits_data;
    assign w_data[2] = resp_2_bits_data;
    assign w_data[3] = resp_3_bits_data;

    generate
        for (genvar k = 0; k < 4; k++) begin : g_lane
            assign w_shift[k] = w_data[k] >> {w_off[k], 3'b000};
        end
    endgenerate

    // Lowest lane wins when several valid lanes target the same slot.
    always_comb begin
        w_ready = '0;
        for (int k = 0; k < 4; k++) begin
            w_ready[k] = (r_state == S_COLLECT);
            for (int j = 0; j < 4; j++) begin
                if (j < k && w_valid[j] && (w_widx[j] == w_widx[k])) begin
                    w_ready[k] = 1'b0;
                end
            end
        end
    end

    assign w_accept = w_valid & w_ready;

    always_comb begin
        w_good = '0;
        w_fill = '0;
        w_bad  = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (w_accept[k]) begin
                if (r_expect[w_widx[k]] && !r_mask[w_widx[k]]) begin
                    w_good[k]         = 1'b1;
                    w_fill[w_widx[k]] = 1'b1;
                end else begin
                    w_bad = 1'b1;
                end
            end
        end
    end

    // Hit when this cycle's increment would bring the counter to TIMEOUT.
    assign w_tcnt_hit = (({1'b0, r_tcnt} + 9'd1) == 9'(TIMEOUT));
    assign w_timeout  = (r_state == S_COLLECT) && (w_fill == 4'd0)
                        && ((r_mask | w_fill) != r_expect) && w_tcnt_hit;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start_valid) begin
                    w_state_nxt = (start_bits_expect == 4'd0) ? S_DONE : S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (((r_mask | w_fill) == r_expect) || w_timeout) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_expect <= '0;
            r_mask   <= '0;
            r_error  <= 1'b0;
            r_tcnt   <= '0;
            for (int i = 0; i < 4; i++) begin
                r_slot[i] <= '0;
            end
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_IDLE && start_valid) begin
                r_expect <= start_bits_expect;
                r_mask   <= '0;
                r_error  <= 1'b0;
                r_tcnt   <= '0;
                for (int i = 0; i < 4; i++) begin
                    r_slot[i] <= '0;
                end
            end else if (r_state == S_COLLECT) begin
                r_mask  <= r_mask | w_fill;
                r_error <= r_error | w_bad | w_timeout;
                r_tcnt  <= (w_fill != 4'd0) ? 8'd0 : r_tcnt + 8'd1;
                for (int k = 0; k < 4; k++) begin
                    if (w_good[k]) begin
                        r_slot[w_widx[k]] <= w_shift[k];
                    end
                end
            end
        end
    end

    assign start_ready    = (r_state == S_IDLE);
    assign out_valid      = (r_state == S_DONE);
    assign out_bits_mask  = r_mask;
    assign out_bits_error = r_error;
    assign resp_0_ready   = w_ready[0];
    assign resp_1_ready   = w_ready[1];
    assign resp_2_ready   = w_ready[2];
    assign resp_3_ready   = w_ready[3];

    generate
        for (genvar i = 0; i < 4; i++) begin : g_out
            assign out_bits_data[DATA_WIDTH*i +: DATA_WIDTH] = r_slot[i];
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_mask_unit_read_response_gather.sv
`default_nettype none
// ============================================================================
// Module   : tb_mask_unit_read_response_gather
// Purpose  : Scoreboard bench for the read-response gather block.
// Revision : 1.0
// ============================================================================
module tb_mask_unit_read_response_gather;

    localparam int DW = 32;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          sv = 1'b0;
    logic          sr;
    logic [3:0]    se = '0;
    logic          lv [4];
    logic          lr [4];
    logic [DW-1:0] ld [4];
    logic [1:0]    lw [4];
    logic [1:0]    lo [4];
    logic          ov;
    logic          oready = 1'b1;
    logic [4*DW-1:0] od;
    logic [3:0]    om;
    logic          oe;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [127:0] data;
        logic [3:0]   mask;
        logic         err;
    } grp_t;
    grp_t sb [$];

    always #5 clock = ~clock;

    mask_unit_read_response_gather #(.DATA_WIDTH(DW), .TIMEOUT(4)) dut (
        .clock(clock), .reset(reset),
        .start_valid(sv), .start_ready(sr), .start_bits_expect(se),
        .resp_0_valid(lv[0]), .resp_0_ready(lr[0]), .resp_0_bits_data(ld[0]),
        .resp_0_bits_writeIndex(lw[0]), .resp_0_bits_dataOffset(lo[0]),
        .resp_1_valid(lv[1]), .resp_1_ready(lr[1]), .resp_1_bits_data(ld[1]),
        .resp_1_bits_writeIndex(lw[1]), .resp_1_bits_dataOffset(lo[1]),
        .resp_2_valid(lv[2]), .resp_2_ready(lr[2]), .resp_2_bits_data(ld[2]),
        .resp_2_bits_writeIndex(lw[2]), .resp_2_bits_dataOffset(lo[2]),
        .resp_3_valid(lv[3]), .resp_3_ready(lr[3]), .resp_3_bits_data(ld[3]),
        .resp_3_bits_writeIndex(lw[3]), .resp_3_bits_dataOffset(lo[3]),
        .out_valid(ov), .out_ready(oready),
        .out_bits_data(od), .out_bits_mask(om), .out_bits_error(oe)
    );

    task automatic check_value(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] rdy_vec();
        return {lr[3], lr[2], lr[1], lr[0]};
    endfunction

    task automatic cyc();
        @(negedge clock);
    endtask

    task automatic clr_lanes();
        for (int k = 0; k < 4; k++) begin
            lv[k] = 1'b0; ld[k] = '0; lw[k] = '0; lo[k] = '0;
        end
    endtask

    task automatic lane(input int k, input logic [1:0] wi, input logic [1:0] off, input logic [DW-1:0] d);
        lv[k] = 1'b1; lw[k] = wi; lo[k] = off; ld[k] = d;
    endtask

    task automatic push(input logic [127:0] d, input logic [3:0] m, input logic e);
        grp_t g;
        g.data = d; g.mask = m; g.err = e;
        sb.push_back(g);
    endtask

    // Returns at the first negedge after the start handshake has fired.
    task automatic start_grp(input logic [3:0] e);
        int n = 0;
        while (!sr && n < 20) begin
            cyc();
            n++;
        end
        if (!sr) check_value("start_timeout", {127'd0, sr}, 128'd1);
        sv = 1'b1; se = e;
        cyc();
        sv = 1'b0; se = '0;
    endtask

    // Output-side scoreboard: pops on every accepted group.
    initial begin
        grp_t g;
        forever begin
            @(negedge clock);
            #2;
            if (reset && ov && oready) begin
                if (sb.size() == 0) begin
                    check_value("sb_unexpected_out", 128'd1, 128'd0);
                end else begin
                    g = sb.pop_front();
                    check_value("out_data", od, g.data);
                    check_value("out_mask", {124'd0, om}, {124'd0, g.mask});
                    check_value("out_error", {127'd0, oe}, {127'd0, g.err});
                end
            end
        end
    end

    initial begin
        logic [3:0]    e;
        logic [3:0]    rem;
        logic [127:0]  exp_d;
        int            s;
        logic [1:0]    ws [4];
        logic [1:0]    os [4];
        logic [DW-1:0] ds [4];
        int            ks [4];
        int            nf;

        clr_lanes();
        cyc(); cyc();
        check_value("rst_start_ready", {127'd0, sr}, 128'd1);
        check_value("rst_out_valid", {127'd0, ov}, 128'd0);
        check_value("rst_data", od, 128'd0);
        check_value("rst_mask", {124'd0, om}, 128'd0);
        check_value("rst_error", {127'd0, oe}, 128'd0);
        check_value("rst_ready", {124'd0, rdy_vec()}, 128'd0);
        reset = 1'b1;
        cyc();

        // Full group, all four lanes in one cycle, reversed slot order
        push({32'hA0, 32'hA1, 32'hA2, 32'hA3}, 4'hF, 1'b0);
        start_grp(4'hF);
        for (int k = 0; k < 4; k++) lane(k, 2'(3 - k), 2'd0, 32'hA0 + 32'(k));
        #1 check_value("norm_ready", {124'd0, rdy_vec()}, 128'hF);
        cyc(); clr_lanes();
        check_value("norm_latency", {127'd0, ov}, 128'd1);
        cyc();
        check_value("norm_back_idle", {127'd0, sr}, 128'd1);

        // Two lanes aim at slot 2: lane 1 wins, lane 2 later lands as duplicate
        push({32'h0, 32'hB1, 32'h0, 32'hB0}, 4'h5, 1'b1);
        start_grp(4'h5);
        lane(1, 2'd2, 2'd0, 32'hB1);
        lane(2, 2'd2, 2'd0, 32'hB2);
        #1 check_value("cont_ready", {124'd0, rdy_vec()}, 128'hB);
        cyc();
        lv[1] = 1'b0;
        lane(0, 2'd0, 2'd0, 32'hB0);
        #1 check_value("cont_dup_ready", {127'd0, lr[2]}, 128'd1);
        cyc(); clr_lanes();
        check_value("cont_latency", {127'd0, ov}, 128'd1);
        cyc();

        // Byte-offset extraction
        push({32'h000000DE, 32'h0, 32'h00001122, 32'h0}, 4'hA, 1'b0);
        start_grp(4'hA);
        lane(3, 2'd1, 2'd2, 32'h11223344);
        lane(0, 2'd3, 2'd3, 32'hDEADBEEF);
        cyc(); clr_lanes();
        check_value("off_latency", {127'd0, ov}, 128'd1);
        cyc();

        // Timeout: slot 1 never arrives
        push({32'h0, 32'h0, 32'h0, 32'h55}, 4'h1, 1'b1);
        start_grp(4'h3);
        lane(0, 2'd0, 2'd0, 32'h55);
        cyc(); clr_lanes();
        for (int i = 1; i <= 4; i++) begin
            check_value("to_not_yet", {127'd0, ov}, 128'd0);
            cyc();
        end
        check_value("to_done", {127'd0, ov}, 128'd1);
        cyc();

        // Back-pressure: outputs hold while out_ready is low
        oready = 1'b0;
        push({32'h0, 32'h0, 32'h0, 32'h77}, 4'h1, 1'b0);
        start_grp(4'h1);
        lane(2, 2'd0, 2'd1, 32'h00007788);
        cyc(); clr_lanes();
        for (int i = 0; i < 10; i++) begin
            check_value("bp_valid", {127'd0, ov}, 128'd1);
            check_value("bp_data", od, {32'h0, 32'h0, 32'h0, 32'h77});
            check_value("bp_mask", {124'd0, om}, 128'd1);
            cyc();
        end
        oready = 1'b1;
        cyc();
        check_value("bp_idle", {127'd0, sr}, 128'd1);

        // Reset in the middle of COLLECT drops the partial group
        start_grp(4'hF);
        lane(0, 2'd0, 2'd0, 32'h1234);
        cyc(); clr_lanes();
        lane(1, 2'd1, 2'd0, 32'h5678);
        reset = 1'b0;
        #1;
        check_value("mrst_start_ready", {127'd0, sr}, 128'd1);
        check_value("mrst_out_valid", {127'd0, ov}, 128'd0);
        check_value("mrst_data", od, 128'd0);
        check_value("mrst_mask", {124'd0, om}, 128'd0);
        check_value("mrst_error", {127'd0, oe}, 128'd0);
        check_value("mrst_ready", {124'd0, rdy_vec()}, 128'd0);
        cyc(); clr_lanes();
        reset = 1'b1;
        cyc();

        // Empty group
        push(128'd0, 4'h0, 1'b0);
        start_grp(4'h0);
        check_value("empty_latency", {127'd0, ov}, 128'd1);
        cyc();

        // Random groups: one fill per cycle on a random lane, slot and offset
        for (int g = 0; g < 15; g++) begin
            e = 4'($urandom_range(1, 15));
            rem = e;
            exp_d = '0;
            nf = 0;
            while (rem != 4'd0) begin
                s = $urandom_range(0, 3);
                if (rem[s]) begin
                    ws[nf] = 2'(s);
                    os[nf] = 2'($urandom_range(0, 3));
                    ds[nf] = $urandom;
                    ks[nf] = $urandom_range(0, 3);
                    exp_d[32*s +: 32] = ds[nf] >> (8 * os[nf]);
                    rem[s] = 1'b0;
                    nf++;
                end
            end
            push(exp_d, e, 1'b0);
            start_grp(e);
            for (int i = 0; i < nf; i++) begin
                lane(ks[i], ws[i], os[i], ds[i]);
                cyc(); clr_lanes();
            end
            check_value("rnd_latency", {127'd0, ov}, 128'd1);
            cyc();
        end

        cyc(); cyc(); cyc();
        check_value("sb_drained", 128'(sb.size()), 128'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mask_unit_read_response_gather.md
# mask_unit_read_response_gather

Collects the lane read responses produced by the read requests that the mask-unit read crossbar issues. It reassembles them into one 4-slot group indexed by the crossbar's `writeIndex` tag and hands the group to the mask unit through a single ready/valid port. One group is in flight at a time. A timeout counter guarantees forward progress if an expected response never arrives.

## Interface
Parameters:
- `DATA_WIDTH`, 32: width of one lane read response and of one group slot.
- `TIMEOUT`, 255: number of consecutive no-progress cycles in COLLECT before the group is forced out; range 1..255.

Ports:
- `clock`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start_valid`  in  1  a new group is requested.
- `start_ready`  out  1  high only in IDLE.
- `start_bits_expect`  in  4  bit i set means a response with writeIndex i is expected.
- `resp_k_valid`  in  1  lane k (k=0..3) has a read response.
- `resp_k_ready`  out  1  response from lane k is accepted this cycle.
- `resp_k_bits_data`  in  DATA_WIDTH  raw lane read data.
- `resp_k_bits_writeIndex`  in  2  destination slot, as tagged by the crossbar.
- `resp_k_bits_dataOffset`  in  2  byte offset of the element within `data`.
- `out_valid`  out  1  an assembled group is available.
- `out_ready`  in  1  the consumer takes the group.
- `out_bits_data`  out  4*DATA_WIDTH  slot i occupies bits [DATA_WIDTH*i +: DATA_WIDTH].
- `out_bits_mask`  out  4  slots actually filled.
- `out_bits_error`  out  1  timeout, or an unexpected or duplicate response, occurred in this group.

## Operation
- FSM states are IDLE, COLLECT and DONE; the reset state is IDLE.
- **IDLE**
  - `start_ready`=1 and all `resp_k_ready`=0.
  - On start fire: latch `expect`, clear the slots, the filled mask, the error flag and the timeout counter.
  - Next state is COLLECT, or DONE if `expect`==0.
- **COLLECT, response acceptance**
  - `resp_k_ready`=1 except when a lower-numbered lane is valid with the same `writeIndex` in the same cycle. Lowest lane index wins; the losing lane holds its response.
  - Accepted data is stored as `data >> (8*dataOffset)`, zero-filled, truncated to DATA_WIDTH.
- **COLLECT, unexpected or duplicate responses**
  - Applies when the response's slot is not in `expect`, or is already filled.
  - The response is accepted (ready=1) and its data is dropped.
  - The error flag is set, and it is sticky until the next start.
- **COLLECT, exit**
  - Next state is DONE when (filled | newly accepted valid slots) == `expect`.
  - Next state is DONE with error=1 when the timeout counter reaches TIMEOUT.
- **Timeout counter**
  - 8-bit counter, cleared on any cycle that fills an expected slot, otherwise incremented.
- **DONE**
  - `out_valid`=1 and all `resp_k_ready`=0.
  - Outputs are stable until `out_ready`; on out fire, next state is IDLE.
- **Output contents**
  - `out_bits_mask` = filled slots.
  - Unfilled slots read 0.
- Reset mid-operation returns to IDLE immediately and discards any partial group.

## Timing
- Reset values:
  - `start_ready`=1, `out_valid`=0.
  - `out_bits_data`=0, `out_bits_mask`=0, `out_bits_error`=0.
  - All `resp_k_ready`=0.
- Start fire in cycle T: COLLECT in T+1, where responses are first accepted.
- Last expected response accepted in cycle T: `out_valid`=1 in T+1.
- Group with `expect`==0: `out_valid`=1 the cycle after start fire.
- Timeout: with no progress after entering COLLECT, DONE is reached TIMEOUT+1 cycles after the last progress event (or after COLLECT entry).
- Out fire in cycle T: IDLE in T+1, so `start_ready`=1 in T+1.
- Minimum group period is 3 cycles (start, one collect, out).
- All ready outputs depend combinationally on state and `resp_k_valid`/`writeIndex` only, never on `out_ready`; there are no combinational paths from `start_*` to `resp_*`.

## Test plan
- **Normal group:** `expect`=4'hF; lanes 0..3 respond in one cycle with writeIndex 3,2,1,0 and data 0xA0..0xA3, dataOffset 0. Next cycle `out_valid`=1, slot3=0xA0, slot0=0xA3, mask=F, error=0.
- **Contention:** lanes 1 and 2 are both valid with writeIndex 2. Lane 1 is accepted and lane 2 sees ready=0. Lane 2 then sees ready=1 next cycle, is treated as a duplicate, and error=1.
- **Offset extraction:** data=0x11223344, dataOffset=2. Slot value is 0x00001122.
- **Timeout:** TIMEOUT=4, `expect`=4'h3, only slot 0 ever returns. DONE is reached 5 cycles after that acceptance, with mask=1, error=1 and slot1=0.
- **Back-pressure and reset:** hold `out_ready`=0 for 10 cycles; outputs stay stable. Then assert `reset` low while in COLLECT; all outputs return to their reset values and `start_ready`=1.
- **Empty group:** `expect`=0 gives `out_valid` one cycle after start fire, with mask=0 and error=0.
